// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package arb_pkg;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_D
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data-stage and backing-memory signals of the arbiter; the slave modport is the arbiter's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_gnt_o;
    logic                  if_rvalid_o;
    logic [DATA_WIDTH-1:0] if_rdata_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic                  d_gnt_o;
    logic                  d_rvalid_o;
    logic [DATA_WIDTH-1:0] d_rdata_o;

    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  stall_f_o;
    logic                  stall_m_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output stall_f_o, stall_m_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  stall_f_o, stall_m_o
    );

endinterface

// File: rtl/mem_port_arbiter_perf_cnt.sv
// Saturating event counter with enable and synchronous reset, used for arbiter statistics.
module arb_perf_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (IF) and data stage (D): D has priority, IF wins after
// STARVE_LIMIT back-to-back D grants. Define ARB_PERF_CNT_EN to add grant/stall counters.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
`ifdef ARB_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH    = 16
`endif
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] perf_if_gnt_o,
    output logic [CNT_WIDTH-1:0] perf_d_gnt_o,
    output logic [CNT_WIDTH-1:0] perf_stall_o
`endif
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    arb_state_e              state_q, state_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;
    logic                    d_we_q, d_we_d;
    arb_owner_e              winner;

    logic                  if_gnt, d_gnt, if_rvalid, d_rvalid;
    logic                  mem_req, mem_we, stall_f, stall_m;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata, if_rdata, d_rdata;

    always_comb begin
        winner = OWN_NONE;
        if (bus.d_req_i && ((starve_q < LIMIT) || !bus.if_req_i)) begin
            winner = OWN_D;
        end else if (bus.if_req_i) begin
            winner = OWN_IF;
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d   = state_q;
        d_we_d    = d_we_q;
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        if_rvalid = 1'b0;
        d_rvalid  = 1'b0;
        if_rdata  = '0;
        d_rdata   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        stall_f   = 1'b0;
        stall_m   = 1'b0;
        // While reset is held every output stays quiet, even if the old state is still BUSY.
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (winner == OWN_D) begin
                        mem_req   = 1'b1;
                        mem_we    = bus.d_we_i;
                        mem_addr  = bus.d_addr_i;
                        mem_wdata = bus.d_wdata_i;
                        d_gnt     = bus.mem_gnt_i;
                        if (bus.mem_gnt_i) begin
                            state_d = BUSY_D;
                            d_we_d  = bus.d_we_i;
                        end
                    end else if (winner == OWN_IF) begin
                        mem_req  = 1'b1;
                        mem_addr = bus.if_addr_i;
                        if_gnt   = bus.mem_gnt_i;
                        if (bus.mem_gnt_i) begin
                            state_d = BUSY_IF;
                        end
                    end
                end
                BUSY_IF: begin
                    if (bus.mem_rvalid_i) begin
                        if_rvalid = 1'b1;
                        if_rdata  = bus.mem_rdata_i;
                        state_d   = IDLE;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_rvalid_i) begin
                        d_rvalid = 1'b1;
                        d_rdata  = d_we_q ? '0 : bus.mem_rdata_i;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            stall_f = (bus.if_req_i && !if_gnt) || ((state_q == BUSY_IF) && !bus.mem_rvalid_i);
            stall_m = (bus.d_req_i && !d_gnt) || ((state_q == BUSY_D) && !bus.mem_rvalid_i);
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req_i || if_gnt) begin
            starve_d = '0;
        end else if (d_gnt && (starve_q != LIMIT)) begin
            starve_d = starve_q + STARVE_CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            starve_q <= '0;
            d_we_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            d_we_q   <= d_we_d;
        end
    end

    assign bus.if_gnt_o    = if_gnt;
    assign bus.if_rvalid_o = if_rvalid;
    assign bus.if_rdata_o  = if_rdata;
    assign bus.d_gnt_o     = d_gnt;
    assign bus.d_rvalid_o  = d_rvalid;
    assign bus.d_rdata_o   = d_rdata;
    assign bus.mem_req_o   = mem_req;
    assign bus.mem_we_o    = mem_we;
    assign bus.mem_addr_o  = mem_addr;
    assign bus.mem_wdata_o = mem_wdata;
    assign bus.stall_f_o   = stall_f;
    assign bus.stall_m_o   = stall_m;

`ifdef ARB_PERF_CNT_EN
    arb_perf_cnt #(.WIDTH(CNT_WIDTH)) u_perf_if (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (if_gnt),
        .cnt_o (perf_if_gnt_o)
    );

    arb_perf_cnt #(.WIDTH(CNT_WIDTH)) u_perf_d (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (d_gnt),
        .cnt_o (perf_d_gnt_o)
    );

    arb_perf_cnt #(.WIDTH(CNT_WIDTH)) u_perf_stall (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (stall_f | stall_m),
        .cnt_o (perf_stall_o)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction-level model is compared every cycle,
// plus hand-computed expectations for each scenario (perf counters when ARB_PERF_CNT_EN is set).
module tb_mem_port_arbiter;

    localparam int STARVE_LIMIT = 4;

    typedef enum int {M_NONE, M_IF, M_D} own_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [15:0] perf_if_gnt, perf_d_gnt, perf_stall;
`endif

    mem_port_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_gnt_o (perf_if_gnt),
        .perf_d_gnt_o  (perf_d_gnt),
        .perf_stall_o  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    own_t m_busy   = M_NONE;
    logic m_write  = 1'b0;
    int   m_streak = 0;
    int   grant_log[$];
    int   m_perf_if = 0, m_perf_d = 0, m_perf_stall = 0;

    logic        e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_mreq, e_mwe, e_sf, e_sm;
    logic [31:0] e_if_rd, e_d_rd, e_maddr, e_mwd;

    always @(negedge clk) begin : compare
        own_t pick;
        pick = M_NONE;
        e_if_gnt = 1'b0; e_d_gnt = 1'b0; e_if_rv = 1'b0; e_d_rv = 1'b0;
        e_mreq = 1'b0; e_mwe = 1'b0; e_sf = 1'b0; e_sm = 1'b0;
        e_if_rd = '0; e_d_rd = '0; e_maddr = '0; e_mwd = '0;
        if (!rst) begin
            if (m_busy == M_NONE) begin
                if (bus.d_req_i && (m_streak < STARVE_LIMIT || !bus.if_req_i)) pick = M_D;
                else if (bus.if_req_i) pick = M_IF;
                if (pick == M_D) begin
                    e_mreq = 1'b1; e_mwe = bus.d_we_i; e_maddr = bus.d_addr_i;
                    e_mwd = bus.d_wdata_i; e_d_gnt = bus.mem_gnt_i;
                end else if (pick == M_IF) begin
                    e_mreq = 1'b1; e_maddr = bus.if_addr_i; e_if_gnt = bus.mem_gnt_i;
                end
            end else if (bus.mem_rvalid_i) begin
                if (m_busy == M_IF) begin
                    e_if_rv = 1'b1; e_if_rd = bus.mem_rdata_i;
                end else begin
                    e_d_rv = 1'b1; e_d_rd = m_write ? 32'h0 : bus.mem_rdata_i;
                end
            end
            e_sf = (bus.if_req_i && !e_if_gnt) || (m_busy == M_IF && !bus.mem_rvalid_i);
            e_sm = (bus.d_req_i && !e_d_gnt) || (m_busy == M_D && !bus.mem_rvalid_i);
        end

        check_bit ("if_gnt",    bus.if_gnt_o,    e_if_gnt);
        check_bit ("d_gnt",     bus.d_gnt_o,     e_d_gnt);
        check_bit ("if_rvalid", bus.if_rvalid_o, e_if_rv);
        check_bit ("d_rvalid",  bus.d_rvalid_o,  e_d_rv);
        check_word("if_rdata",  bus.if_rdata_o,  e_if_rd);
        check_word("d_rdata",   bus.d_rdata_o,   e_d_rd);
        check_bit ("mem_req",   bus.mem_req_o,   e_mreq);
        check_bit ("mem_we",    bus.mem_we_o,    e_mwe);
        check_word("mem_addr",  bus.mem_addr_o,  e_maddr);
        check_word("mem_wdata", bus.mem_wdata_o, e_mwd);
        check_bit ("stall_f",   bus.stall_f_o,   e_sf);
        check_bit ("stall_m",   bus.stall_m_o,   e_sm);
`ifdef ARB_PERF_CNT_EN
        check_word("perf_if",    32'(perf_if_gnt), m_perf_if);
        check_word("perf_d",     32'(perf_d_gnt),  m_perf_d);
        check_word("perf_stall", 32'(perf_stall),  m_perf_stall);
`endif

        if (rst) begin
            m_busy = M_NONE; m_streak = 0;
            m_perf_if = 0; m_perf_d = 0; m_perf_stall = 0;
        end else begin
            if (e_if_gnt) begin
                m_busy = M_IF; grant_log.push_back(M_IF); m_perf_if++;
            end else if (e_d_gnt) begin
                m_busy = M_D; m_write = bus.d_we_i; grant_log.push_back(M_D); m_perf_d++;
            end else if (m_busy != M_NONE && bus.mem_rvalid_i) begin
                m_busy = M_NONE;
            end
            if (!bus.if_req_i || e_if_gnt) m_streak = 0;
            else if (e_d_gnt && m_streak < STARVE_LIMIT) m_streak++;
            if (e_sf || e_sm) m_perf_stall++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic ifr, input logic [31:0] ifa, input logic dr, input logic dwe,
                          input logic [31:0] da, input logic [31:0] dwd, input logic mg,
                          input logic mrv, input logic [31:0] mrd);
        bus.if_req_i = ifr;  bus.if_addr_i = ifa;
        bus.d_req_i = dr;    bus.d_we_i = dwe;  bus.d_addr_i = da;  bus.d_wdata_i = dwd;
        bus.mem_gnt_i = mg;  bus.mem_rvalid_i = mrv;  bus.mem_rdata_i = mrd;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "simulation time limit reached");
    end

    initial begin : driver
        int exp_order[10];
        exp_order = '{M_D, M_D, M_D, M_D, M_IF, M_D, M_D, M_D, M_D, M_IF};

        // Reset with live requests and a stray response: everything must stay quiet.
        rst = 1'b1;
        set_in(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 1'b1, 32'h1234);
        settle();
        check_bit("rst_mem_req", bus.mem_req_o, 1'b0);
        check_bit("rst_if_gnt", bus.if_gnt_o, 1'b0);
        check_bit("rst_d_rvalid", bus.d_rvalid_o, 1'b0);
        check_bit("rst_stall_f", bus.stall_f_o, 1'b0);
        advance();
        advance();

        // 1: IF-only fetch of 0x0, response next cycle.
        rst = 1'b0;
        set_in(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        check_bit("t1_if_gnt", bus.if_gnt_o, 1'b1);
        check_bit("t1_mem_we", bus.mem_we_o, 1'b0);
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
        settle();
        check_bit("t1_if_rvalid", bus.if_rvalid_o, 1'b1);
        check_word("t1_if_rdata", bus.if_rdata_o, 32'hDEADBEEF);
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        settle();
        check_bit("t1_stall_f_after", bus.stall_f_o, 1'b0);
        advance();

        // 2: IF and D collide; D write 0x100 <= 5 goes first, IF next.
        set_in(1'b1, 32'h44, 1'b1, 1'b1, 32'h100, 32'h5, 1'b1, 1'b0, 32'h0);
        settle();
        check_bit("t2_d_gnt", bus.d_gnt_o, 1'b1);
        check_bit("t2_if_gnt", bus.if_gnt_o, 1'b0);
        check_bit("t2_mem_we", bus.mem_we_o, 1'b1);
        check_word("t2_mem_addr", bus.mem_addr_o, 32'h100);
        check_word("t2_mem_wdata", bus.mem_wdata_o, 32'h5);
        advance();
        set_in(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF);
        settle();
        check_bit("t2_d_ack", bus.d_rvalid_o, 1'b1);
        check_word("t2_d_ack_rdata", bus.d_rdata_o, 32'h0);
        advance();
        set_in(1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        check_bit("t2_if_gnt_next", bus.if_gnt_o, 1'b1);
        check_word("t2_if_addr", bus.mem_addr_o, 32'h44);
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hCAFE0001);
        advance();

        // 4: memory withholds its grant for 3 cycles on a D read of 0x200.
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h0);
            settle();
            check_bit("t4_mem_req", bus.mem_req_o, 1'b1);
            check_bit("t4_d_gnt", bus.d_gnt_o, 1'b0);
            check_bit("t4_stall_m", bus.stall_m_o, 1'b1);
            advance();
        end
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        check_bit("t4_d_gnt_late", bus.d_gnt_o, 1'b1);
        advance();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0BADF00D);
        settle();
        check_word("t4_d_rdata", bus.d_rdata_o, 32'h0BADF00D);
        advance();
        // Spurious response while idle.
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h77);
        settle();
        check_bit("idle_spurious_d_rvalid", bus.d_rvalid_o, 1'b0);
        check_bit("idle_spurious_if_rvalid", bus.if_rvalid_o, 1'b0);
        advance();

        // 5: reset while BUSY_D, then the late response must be dropped.
        set_in(1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 32'h0);
        settle();
        check_bit("t5_d_gnt", bus.d_gnt_o, 1'b1);
        advance();
        rst = 1'b1;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        advance();
        rst = 1'b0;
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h55);
        settle();
        check_bit("t5_d_rvalid_dropped", bus.d_rvalid_o, 1'b0);
        check_word("t5_d_rdata", bus.d_rdata_o, 32'h0);
        check_bit("t5_stall_m", bus.stall_m_o, 1'b0);
        advance();

        // 3: both sides request continuously; expect D,D,D,D,IF,D,D,D,D,IF.
        grant_log.delete();
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 32'h1000, 1'b1, 1'b0, 32'h2000, 32'h0, 1'b1, (i % 2) == 1, 32'(i));
            advance();
        end
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        settle();
        check_word("t3_grant_count", 32'(grant_log.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check_word($sformatf("t3_grant_%0d", i),
                       (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFFFFFF,
                       32'(exp_order[i]));
        end
`ifdef ARB_PERF_CNT_EN
        check_word("t6_perf_d", 32'(perf_d_gnt), 32'd8);
        check_word("t6_perf_if", 32'(perf_if_gnt), 32'd2);
`endif
        advance();
        advance();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
